// File: rtl/mtm_alu_frame_ctrl_pkg.sv
// rtl/mtm_alu_frame_ctrl_pkg.sv - shared constants, FSM state type and CRC-4 helpers for the ALU frame controller
package mtm_alu_frame_ctrl_pkg;

   // Operation codes accepted by the datapath
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   // Frame type bit values
   localparam logic FRAME_DATA = 1'b0;
   localparam logic FRAME_CTL  = 1'b1;

   // Bit positions inside err_flags = {ERR_DATA, ERR_CRC, ERR_OP}
   localparam int ERR_DATA_BIT = 2;
   localparam int ERR_CRC_BIT  = 1;
   localparam int ERR_OP_BIT   = 0;

   // x^4 + x + 1, with the implicit x^4 term dropped
   localparam logic [3:0] CRC4_POLY = 4'h3;

   // Number of DATA frames that make up one operation (B then A)
   localparam logic [3:0] DATA_BYTES = 4'd8;

   // Receiver bit position of the stop bit (start = 0, type = 1, payload = 2..9)
   localparam logic [3:0] STOP_POS = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_ISSUE   = 2'd2
   } state_t;

   // One MSB-first CRC-4 shift step
   function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
      logic fb;
      fb = crc[3] ^ din;
      return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'h0);
   endfunction

   // Fold a whole byte into the running CRC, MSB first
   function automatic logic [3:0] crc4_byte(input logic [3:0] crc, input logic [7:0] data);
      logic [3:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         c = crc4_step(c, data[i]);
      end
      return c;
   endfunction

   // Fold a nibble into the running CRC, MSB first
   function automatic logic [3:0] crc4_nibble(input logic [3:0] crc, input logic [3:0] data);
      logic [3:0] c;
      c = crc;
      for (int i = 3; i >= 0; i--) begin
         c = crc4_step(c, data[i]);
      end
      return c;
   endfunction

   function automatic logic op_supported(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/mtm_alu_frame_ctrl_rx.sv
// rtl/mtm_alu_frame_ctrl_rx.sv - serial frame deserializer (module mtm_alu_frame_rx)
module mtm_alu_frame_rx
   import mtm_alu_frame_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sin,
   output logic       frame_start,
   output logic       frame_valid,
   output logic       frame_type,
   output logic [7:0] payload
);

   logic       busy;
   logic [3:0] bit_cnt;
   logic       type_q;
   logic [7:0] shift_q;

   // frame_valid is raised while the good stop bit is on the line so the
   // controller can register its response on that same edge
   assign frame_start = !busy && !sin;
   assign frame_valid = busy && (bit_cnt == STOP_POS) && sin;
   assign frame_type  = type_q;
   assign payload     = shift_q;

   // Hunt for a start bit, then capture type and payload; a bad stop bit
   // simply falls back to hunting without raising frame_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         bit_cnt <= 4'd0;
         type_q  <= 1'b0;
         shift_q <= 8'h00;
      end else if (!busy) begin
         if (!sin) begin
            busy    <= 1'b1;
            bit_cnt <= 4'd1;
         end
      end else begin
         if (bit_cnt == 4'd1) begin
            type_q <= sin;
         end else if (bit_cnt != STOP_POS) begin
            shift_q <= {shift_q[6:0], sin};
         end
         if (bit_cnt == STOP_POS) begin
            busy    <= 1'b0;
            bit_cnt <= 4'd0;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/mtm_alu_frame_ctrl.sv
// rtl/mtm_alu_frame_ctrl.sv - ALU frame controller top; optional CRC check via MTM_ALU_CRC_CHECK_EN
module mtm_alu_frame_ctrl
   import mtm_alu_frame_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [2:0]  op_mode,
   output logic        op_valid,
   input  logic        op_ready,
   output logic        err_valid,
   output logic [2:0]  err_flags
);

   localparam bit          TO_EN    = (TIMEOUT_CYCLES > 0);
   localparam logic [31:0] TO_LIMIT = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   logic        rx_start;
   logic        rx_valid;
   logic        rx_type;
   logic [7:0]  rx_payload;

   state_t      state;
   logic [3:0]  data_cnt;
   logic [63:0] data_q;
   logic [31:0] idle_cnt;
   logic        timeout_hit;
   logic        crc_bad;
   logic        unused_payload;

   mtm_alu_frame_rx u_rx (
      .clk         (clk),
      .rst         (rst),
      .sin         (sin),
      .frame_start (rx_start),
      .frame_valid (rx_valid),
      .frame_type  (rx_type),
      .payload     (rx_payload)
   );

   assign timeout_hit = TO_EN && (state == ST_COLLECT) && !rx_start && (idle_cnt == TO_LIMIT);

`ifdef MTM_ALU_CRC_CHECK_EN
   logic [3:0] crc_q;
   logic [3:0] crc_final;

   // The trailing {1'b1, OP} nibble is folded in only when the CTL frame arrives
   assign crc_final      = crc4_nibble(crc_q, {1'b1, rx_payload[6:4]});
   assign crc_bad        = (crc_final != rx_payload[3:0]);
   assign unused_payload = rx_payload[7];

   // Running CRC over the DATA bytes in arrival order (B first, then A)
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= 4'h0;
      end else if (rx_valid && (rx_type == FRAME_DATA)) begin
         if (state == ST_IDLE) begin
            crc_q <= crc4_byte(4'h0, rx_payload);
         end else if ((state == ST_COLLECT) && (data_cnt != DATA_BYTES)) begin
            crc_q <= crc4_byte(crc_q, rx_payload);
         end
      end
   end
`else
   assign crc_bad        = 1'b0;
   assign unused_payload = ^{rx_payload[7], rx_payload[3:0]};
`endif

   // Idle-gap counter for the COLLECT timeout; restarts on every start bit
   always_ff @(posedge clk) begin
      if (rst || (state != ST_COLLECT) || rx_start) begin
         idle_cnt <= 32'd0;
      end else begin
         idle_cnt <= idle_cnt + 32'd1;
      end
   end

   // Main controller: collect 8 DATA bytes, validate on CTL, hold the operation until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         data_cnt  <= 4'd0;
         data_q    <= 64'd0;
         op_a      <= 32'd0;
         op_b      <= 32'd0;
         op_mode   <= 3'd0;
         op_valid  <= 1'b0;
         err_valid <= 1'b0;
         err_flags <= 3'd0;
      end else begin
         err_valid <= 1'b0;
         err_flags <= 3'd0;
         case (state)
            ST_IDLE: begin
               if (rx_valid) begin
                  if (rx_type == FRAME_DATA) begin
                     data_q   <= {56'd0, rx_payload};
                     data_cnt <= 4'd1;
                     state    <= ST_COLLECT;
                  end else begin
                     err_valid               <= 1'b1;
                     err_flags[ERR_DATA_BIT] <= 1'b1;
                  end
               end
            end
            ST_COLLECT: begin
               if (rx_valid) begin
                  if (rx_type == FRAME_DATA) begin
                     if (data_cnt == DATA_BYTES) begin
                        err_valid               <= 1'b1;
                        err_flags[ERR_DATA_BIT] <= 1'b1;
                        data_cnt                <= 4'd0;
                        state                   <= ST_IDLE;
                     end else begin
                        data_q   <= {data_q[55:0], rx_payload};
                        data_cnt <= data_cnt + 4'd1;
                     end
                  end else begin
                     data_cnt <= 4'd0;
                     state    <= ST_IDLE;
                     if (data_cnt != DATA_BYTES) begin
                        err_valid               <= 1'b1;
                        err_flags[ERR_DATA_BIT] <= 1'b1;
                     end else if (crc_bad) begin
                        err_valid              <= 1'b1;
                        err_flags[ERR_CRC_BIT] <= 1'b1;
                     end else if (!op_supported(rx_payload[6:4])) begin
                        err_valid             <= 1'b1;
                        err_flags[ERR_OP_BIT] <= 1'b1;
                     end else begin
                        op_b     <= data_q[63:32];
                        op_a     <= data_q[31:0];
                        op_mode  <= rx_payload[6:4];
                        op_valid <= 1'b1;
                        state    <= ST_ISSUE;
                     end
                  end
               end else if (timeout_hit) begin
                  err_valid               <= 1'b1;
                  err_flags[ERR_DATA_BIT] <= 1'b1;
                  data_cnt                <= 4'd0;
                  state                   <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (rx_valid) begin
                  err_valid               <= 1'b1;
                  err_flags[ERR_DATA_BIT] <= 1'b1;
               end
               if (op_valid && op_ready) begin
                  op_valid <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mtm_alu_frame_ctrl.md
MTM_ALU_FRAME_CTRL -- requirements
Module: mtm_alu_frame_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 0, giving the inter-frame idle limit in COLLECT; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port sin, input, 1 bit: serial ALU input line, idle high, one bit per clk.
REQ-005 SHALL have port op_a, output, 32 bits: operand A.
REQ-006 SHALL have port op_b, output, 32 bits: operand B.
REQ-007 SHALL have port op_mode, output, 3 bits: operation code.
REQ-008 SHALL have port op_valid, output, 1 bit: operation available to the datapath.
REQ-009 SHALL have port op_ready, input, 1 bit: datapath accepts the operation.
REQ-010 SHALL have port err_valid, output, 1 bit: one-cycle error pulse.
REQ-011 SHALL have port err_flags, output, 3 bits: {ERR_DATA, ERR_CRC, ERR_OP}.

Function
REQ-012 Frame format SHALL be 11 bits: start 0, type (0 DATA / 1 CTL), 8 payload bits MSB first, stop 1. A frame starts at the first sampled 0 while the receiver is idle.
REQ-013 Stop bit = 0 SHALL discard the frame silently; the receiver returns to idle-hunt.
REQ-014 The FSM SHALL have states IDLE, COLLECT, ISSUE. The first DATA frame moves IDLE to COLLECT. Byte order: B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] ... A[7:0].
REQ-015 A CTL payload SHALL decode as {1'b0, OP[2:0], CRC[3:0]}.
REQ-016 CTL with data count != 8 SHALL pulse err_valid with ERR_DATA and return to IDLE.
REQ-017 A 9th DATA frame SHALL pulse err_valid with ERR_DATA, discard all data and return to IDLE.
REQ-018 CRC SHALL be CRC-4, polynomial x^4+x+1, initial value 0, computed MSB first over the 68 bits {B, A, 1'b1, OP}.
REQ-019 CRC mismatch SHALL pulse err_valid with ERR_CRC.
REQ-020 OP not in {000 AND, 001 OR, 100 ADD, 101 SUB} SHALL pulse err_valid with ERR_OP.
REQ-021 Error priority SHALL be DATA > CRC > OP, with exactly one flag set per pulse.
REQ-022 A valid CTL SHALL enter ISSUE and assert op_valid on the cycle after the stop bit is sampled.
REQ-023 op_a, op_b and op_mode SHALL be stable while op_valid=1.
REQ-024 Handshake SHALL complete on op_valid & op_ready. op_valid deasserts on the next cycle and the FSM returns to IDLE.
REQ-025 A frame completing while in ISSUE SHALL be dropped and pulse err_valid with ERR_DATA. op_valid is unaffected.
REQ-026 If TIMEOUT_CYCLES>0 and no start bit is seen for TIMEOUT_CYCLES cycles in COLLECT, the block SHALL discard the partial data, pulse ERR_DATA and go to IDLE.
REQ-027 err_valid and op_valid SHALL be registered outputs.

Reset
REQ-028 rst=1 SHALL force IDLE, receiver idle-hunt, data count 0, CRC 0, op_valid=0, err_valid=0, err_flags=0, op_a=0, op_b=0, op_mode=0.
REQ-029 rst asserted mid-frame or in ISSUE SHALL abort with no error pulse. The first start bit after release begins a new frame.

Configuration
REQ-030 With macro MTM_ALU_CRC_CHECK_EN defined, the block SHALL check CRC per REQ-018/019.
REQ-031 Without MTM_ALU_CRC_CHECK_EN, the CRC field SHALL be ignored, ERR_CRC is never set and the CRC logic is absent.

Structure
REQ-032 A shared package SHALL hold the OP codes, frame type constants, error-flag bit indices, FSM state typedef and the CRC-4 polynomial.
REQ-033 A sub-module mtm_alu_frame_rx SHALL perform frame deserialization and output {frame_valid, frame_type, payload[7:0]} for one cycle.

Verification
REQ-034 B=0x0FFFFFFF, A=0x00005577, OP=001, correct CRC -> op_valid with op_b=0x0FFFFFFF, op_a=0x00005577, op_mode=001.
REQ-035 A=B=0, OP=000, CRC=4'hB -> op_valid, op_a=op_b=0. Repeat with A=B=0xFFFFFFFF for ops 000/001/100/101 using computed CRC -> op_valid each time, no err_valid.
REQ-036 7 DATA frames then CTL -> single err_valid with err_flags=100 and no op_valid. A following valid 9-frame sequence -> op_valid.
REQ-037 Valid data with CRC field XOR 4'h1 -> err_flags=010 (macro defined); op_valid with the macro undefined.
REQ-038 OP=010 with correct CRC -> err_flags=001. op_ready held 0 for 50 cycles -> op_valid held and outputs stable.
REQ-039 rst pulsed after the 4th DATA frame, then a full valid sequence -> exactly one op_valid, no err_valid.
